// File: rtl/fifo_rd_stream.sv
// Read adapter: turns a sync-RAM fifo's re/empty/dataOut port into a valid/ready stream.
// Optional accepted-beat counter port enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      beat_count
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);

  logic [CW-1:0]    credit_q, credit_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             busy_q, busy_d;
  logic             pop;
  logic             land;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop  = m_valid_q & m_ready;
  assign land = infl_q[RD_LAT-1];

  // Issue a read only when the word is guaranteed a buffer slot on return.
  assign fifo_re = !rst && !fifo_empty && ((credit_q - CW'(pop)) < CW'(BUF_DEPTH));

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;

  always_comb begin
    infl_d    = infl_q << 1;
    infl_d[0] = fifo_re;
    head_d    = pop  ? ptr_inc(head_q) : head_q;
    tail_d    = land ? ptr_inc(tail_q) : tail_q;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (land) begin
      mem_d[tail_q] = fifo_data;
    end
    count_d   = count_q + CW'(land) - CW'(pop);
    credit_d  = credit_q + CW'(fifo_re) - CW'(pop);
    m_valid_d = (count_d != '0);
    // Hold the last shown word when the buffer drains; it is not valid then.
    m_data_d  = m_valid_d ? mem_d[head_d] : m_data_q;
    busy_d    = (credit_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      infl_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      credit_q  <= credit_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      infl_q    <= infl_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_q;

  // Saturating count of accepted output beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else if (pop && (beat_q != 32'hFFFF_FFFF)) begin
      beat_q <= beat_q + 32'd1;
    end
  end

  assign beat_count = beat_q;
`endif

endmodule
